// File: rtl/tcm_mem_ram_dp_if.sv
// Bus bundle for the dual-port TCM RAM: two request/response ports plus
// shared ready and collision status.
interface tcm_mem_ram_dp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 13
);
  logic                  req0_i;
  logic                  req1_i;
  logic [ADDR_W-1:0]     addr0_i;
  logic [ADDR_W-1:0]     addr1_i;
  logic [DATA_W-1:0]     data0_i;
  logic [DATA_W-1:0]     data1_i;
  logic [DATA_W/8-1:0]   wr0_i;
  logic [DATA_W/8-1:0]   wr1_i;
  logic [DATA_W-1:0]     data0_o;
  logic [DATA_W-1:0]     data1_o;
  logic                  valid0_o;
  logic                  valid1_o;
  logic                  ready_o;
  logic                  collision_o;

  modport master (
    output req0_i, req1_i, addr0_i, addr1_i, data0_i, data1_i, wr0_i, wr1_i,
    input  data0_o, data1_o, valid0_o, valid1_o, ready_o, collision_o
  );

  modport slave (
    input  req0_i, req1_i, addr0_i, addr1_i, data0_i, data1_i, wr0_i, wr1_i,
    output data0_o, data1_o, valid0_o, valid1_o, ready_o, collision_o
  );
endinterface

// File: rtl/tcm_mem_ram_dp.sv
// Dual-port byte-writable TCM RAM with post-reset clear sequencer,
// port-0 write priority and optional output register stage.
//
// state | meaning
// INIT  | clearing array one word per cycle, ready_o low
// READY | array usable, requests accepted
module tcm_mem_ram_dp #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 13,
  parameter int READ_MODE      = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic             clk_i,
  input logic             rst_i,
  tcm_mem_ram_dp_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc0, acc1, same_addr, overlap;
  logic [DATA_W-1:0] mask0, mask1, old0, old1, merged, rd0, rd1;
  logic              v0_s1, v1_s1;
  logic [DATA_W-1:0] d0_s1, d1_s1;
  logic              collision_q;

  assign bus.ready_o = (state == ST_READY) && !rst_i;
  assign acc0        = bus.req0_i && bus.ready_o;
  assign acc1        = bus.req1_i && bus.ready_o;
  assign same_addr   = (bus.addr0_i == bus.addr1_i);
  assign overlap     = acc0 && acc1 && same_addr && ((bus.wr0_i & bus.wr1_i) != '0);

  always_comb begin
    mask0 = '0;
    mask1 = '0;
    for (int i = 0; i < LANES; i++) begin
      mask0[i*8 +: 8] = {8{acc0 && bus.wr0_i[i]}};
      mask1[i*8 +: 8] = {8{acc1 && bus.wr1_i[i]}};
    end
  end

  assign old0 = mem[bus.addr0_i];
  assign old1 = mem[bus.addr1_i];

  // Post-write word at a shared address: port 1 lanes first, port 0 overrides.
  assign merged = (((old0 & ~mask1) | (bus.data1_i & mask1)) & ~mask0) | (bus.data0_i & mask0);

  assign rd0 = (READ_MODE == 1 && same_addr && mask1 != '0) ? merged : old0;
  assign rd1 = (READ_MODE == 1 && same_addr && mask0 != '0) ? merged : old1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
      clr_addr <= '0;
    end else if (state == ST_INIT) begin
      if (clr_addr == {ADDR_W{1'b1}}) begin
        state <= ST_READY;
      end else begin
        clr_addr <= clr_addr + 1'b1;
      end
    end
  end

  // Port 0 lanes are written last so they take priority on overlap.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == ST_INIT) begin
        mem[clr_addr] <= '0;
      end else begin
        for (int i = 0; i < LANES; i++) begin
          if (acc1 && bus.wr1_i[i]) mem[bus.addr1_i][i*8 +: 8] <= bus.data1_i[i*8 +: 8];
        end
        for (int i = 0; i < LANES; i++) begin
          if (acc0 && bus.wr0_i[i]) mem[bus.addr0_i][i*8 +: 8] <= bus.data0_i[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v0_s1       <= 1'b0;
      v1_s1       <= 1'b0;
      d0_s1       <= '0;
      d1_s1       <= '0;
      collision_q <= 1'b0;
    end else begin
      v0_s1       <= acc0;
      v1_s1       <= acc1;
      collision_q <= overlap;
      if (acc0) d0_s1 <= rd0;
      if (acc1) d1_s1 <= rd1;
    end
  end

  assign bus.collision_o = collision_q;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              v0_s2, v1_s2;
      logic [DATA_W-1:0] d0_s2, d1_s2;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          v0_s2 <= 1'b0;
          v1_s2 <= 1'b0;
          d0_s2 <= '0;
          d1_s2 <= '0;
        end else begin
          v0_s2 <= v0_s1;
          v1_s2 <= v1_s1;
          if (v0_s1) d0_s2 <= d0_s1;
          if (v1_s1) d1_s2 <= d1_s1;
        end
      end

      assign bus.valid0_o = v0_s2;
      assign bus.valid1_o = v1_s2;
      assign bus.data0_o  = d0_s2;
      assign bus.data1_o  = d1_s2;
    end else begin : g_noreg
      assign bus.valid0_o = v0_s1;
      assign bus.valid1_o = v1_s1;
      assign bus.data0_o  = d0_s1;
      assign bus.data1_o  = d1_s1;
    end
  endgenerate
endmodule

// File: tb/tb_tcm_mem_ram_dp.sv
// Bench for tcm_mem_ram_dp: two instances (read-first/no out reg and
// write-first/out reg) share stimulus and are checked against a word-level model.
module tb_tcm_mem_ram_dp;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [3:0]  addr0, addr1;
  logic [63:0] d0, d1;
  logic [7:0]  wr0, wr1;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  always #5 clk = ~clk;

  tcm_mem_ram_dp_if #(.DATA_W(64), .ADDR_W(4)) ifa ();
  tcm_mem_ram_dp_if #(.DATA_W(64), .ADDR_W(4)) ifb ();

  assign ifa.req0_i = req0;  assign ifb.req0_i = req0;
  assign ifa.req1_i = req1;  assign ifb.req1_i = req1;
  assign ifa.addr0_i = addr0; assign ifb.addr0_i = addr0;
  assign ifa.addr1_i = addr1; assign ifb.addr1_i = addr1;
  assign ifa.data0_i = d0;   assign ifb.data0_i = d0;
  assign ifa.data1_i = d1;   assign ifb.data1_i = d1;
  assign ifa.wr0_i = wr0;    assign ifb.wr0_i = wr0;
  assign ifa.wr1_i = wr1;    assign ifb.wr1_i = wr1;

  tcm_mem_ram_dp #(.DATA_W(64), .ADDR_W(4), .READ_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1))
    dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  tcm_mem_ram_dp #(.DATA_W(64), .ADDR_W(4), .READ_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1))
    dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

  // word-level model
  logic [63:0] mm [16];
  int          init_left = 16;
  logic        ea_v0 = 0, ea_v1 = 0, ea_col = 0;
  logic [63:0] ea_d0 = 0, ea_d1 = 0;
  logic        b1_v0 = 0, b1_v1 = 0, eb_v0 = 0, eb_v1 = 0, eb_col = 0;
  logic [63:0] b1_d0 = 0, b1_d1 = 0, eb_d0 = 0, eb_d1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] w);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{w[i]}};
    return m;
  endfunction

  task automatic tick();
    bit          rdy, a0, a1, same, ovl, exp_rdy;
    logic [63:0] m0, m1, old0, old1, rb0, rb1;
    rdy  = !rst && init_left == 0;
    a0   = req0 && rdy;
    a1   = req1 && rdy;
    m0   = lane_mask(wr0);
    m1   = lane_mask(wr1);
    same = (addr0 == addr1);
    old0 = mm[addr0];
    old1 = mm[addr1];
    ovl  = a0 && a1 && same && ((wr0 & wr1) != 0);
    if (a1) mm[addr1] = (mm[addr1] & ~m1) | (d1 & m1);
    if (a0) mm[addr0] = (mm[addr0] & ~m0) | (d0 & m0);
    rb0 = (same && a1 && wr1 != 0) ? mm[addr0] : old0;
    rb1 = (same && a0 && wr0 != 0) ? mm[addr1] : old1;
    @(posedge clk);
    if (rst) begin
      init_left = 16;
      ea_v0 = 0; ea_v1 = 0; ea_d0 = 0; ea_d1 = 0; ea_col = 0;
      b1_v0 = 0; b1_v1 = 0; b1_d0 = 0; b1_d1 = 0;
      eb_v0 = 0; eb_v1 = 0; eb_d0 = 0; eb_d1 = 0; eb_col = 0;
    end else begin
      if (init_left > 0) begin
        init_left--;
        if (init_left == 0) for (int i = 0; i < 16; i++) mm[i] = 64'h0;
      end
      ea_v0 = a0; if (a0) ea_d0 = old0;
      ea_v1 = a1; if (a1) ea_d1 = old1;
      ea_col = ovl;
      eb_v0 = b1_v0; if (b1_v0) eb_d0 = b1_d0;
      eb_v1 = b1_v1; if (b1_v1) eb_d1 = b1_d1;
      b1_v0 = a0; if (a0) b1_d0 = rb0;
      b1_v1 = a1; if (a1) b1_d1 = rb1;
      eb_col = ovl;
    end
    @(negedge clk);
    if (started) begin
      exp_rdy = !rst && init_left == 0;
      chk("a_ready", ifa.ready_o, exp_rdy);
      chk("a_valid0", ifa.valid0_o, ea_v0);
      chk("a_valid1", ifa.valid1_o, ea_v1);
      chk("a_data0", ifa.data0_o, ea_d0);
      chk("a_data1", ifa.data1_o, ea_d1);
      chk("a_collision", ifa.collision_o, ea_col);
      chk("b_ready", ifb.ready_o, exp_rdy);
      chk("b_valid0", ifb.valid0_o, eb_v0);
      chk("b_valid1", ifb.valid1_o, eb_v1);
      chk("b_data0", ifb.data0_o, eb_d0);
      chk("b_data1", ifb.data1_o, eb_d1);
      chk("b_collision", ifb.collision_o, eb_col);
    end
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; addr0 = 0; addr1 = 0; d0 = 0; d1 = 0;
  endtask

  task automatic set0(input logic r, input logic [3:0] a, input logic [63:0] d, input logic [7:0] w);
    req0 = r; addr0 = a; d0 = d; wr0 = w;
  endtask

  task automatic set1(input logic r, input logic [3:0] a, input logic [63:0] d, input logic [7:0] w);
    req1 = r; addr1 = a; d1 = d; wr1 = w;
  endtask

  task automatic rand_inputs();
    req0 = $urandom_range(0, 3) != 0;
    req1 = $urandom_range(0, 3) != 0;
    addr0 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
    addr1 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: wr0 = 8'h00;
      1: wr0 = 8'hFF;
      default: wr0 = 8'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0: wr1 = 8'h00;
      1: wr1 = 8'hFF;
      default: wr1 = 8'($urandom);
    endcase
  endtask

  // rst has just been released; random requests run while clearing
  task automatic wait_ready(output int n);
    n = 0;
    while (!ifa.ready_o && n < 40) begin
      rand_inputs();
      tick();
      n++;
    end
    idle();
  endtask

  initial begin
    int n;
    rst = 1;
    idle();
    tick();
    started = 1;
    tick();

    rst = 0;
    wait_ready(n);
    chk("init_len", n, 16);

    for (int i = 0; i < 16; i++) begin
      set0(1, 4'(i), 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
      set1(1, 4'(15 - i), 64'h0, 8'h00);
      tick();
      chk("clear_rd0", ifa.data0_o, 64'h0);
    end
    idle();
    tick();
    tick();

    set0(1, 4'd3, 64'h1122334455667788, 8'hFF);
    tick();
    idle();
    set1(1, 4'd3, 64'h0, 8'h00);
    tick();
    chk("r33_a_valid", ifa.valid1_o, 1'b1);
    chk("r33_a_data", ifa.data1_o, 64'h1122334455667788);
    chk("r33_b_early", ifb.valid1_o, 1'b0);
    idle();
    tick();
    chk("r33_b_valid", ifb.valid1_o, 1'b1);
    chk("r33_b_data", ifb.data1_o, 64'h1122334455667788);

    set0(1, 4'd5, {8{8'hAA}}, 8'h0F);
    set1(1, 4'd5, {8{8'hBB}}, 8'h3C);
    tick();
    chk("r34_a_col", ifa.collision_o, 1'b1);
    chk("r34_b_col", ifb.collision_o, 1'b1);
    idle();
    set0(1, 4'd5, 64'h0, 8'h00);
    tick();
    chk("r34_word", ifa.data0_o, 64'h0000BBBBAAAAAAAA);
    idle();
    tick();

    set0(1, 4'd7, 64'h1, 8'hFF);
    tick();
    set0(1, 4'd7, 64'h2, 8'hFF);
    set1(1, 4'd7, 64'h0, 8'h00);
    tick();
    chk("r35_rdfirst", ifa.data1_o, 64'h1);
    idle();
    tick();
    chk("r35_wrfirst", ifb.data1_o, 64'h2);

    rst = 1;
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 9; i++) begin
      rand_inputs();
      tick();
    end
    idle();
    rst = 1;
    tick();
    rst = 0;
    wait_ready(n);
    chk("r36_init_len", n, 16);
    set0(1, 4'd3, 64'h0, 8'h00);
    tick();
    chk("r36_rd3", ifa.data0_o, 64'h0);
    idle();

    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0;
    idle();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tcm_mem_ram_dp.md
TCM_MEM_RAM_DP -- requirements
Module: tcm_mem_ram_dp

Interface
REQ-001 Parameter DATA_W, default 64, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 13, address width; depth SHALL be 2^ADDR_W words.
REQ-003 Parameter READ_MODE, default 0; 0 = read-first, 1 = write-first for cross-port same-address reads.
REQ-004 Parameter OUT_REG, default 0; 1 adds one output pipeline stage.
REQ-005 Parameter CLEAR_ON_RESET, default 1; 1 = zero the whole array after reset.
REQ-006 clk_i  in  1  single clock; all logic SHALL be on its rising edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 req0_i / req1_i  in  1  port 0 / port 1 access request.
REQ-009 addr0_i / addr1_i  in  ADDR_W  word address.
REQ-010 data0_i / data1_i  in  DATA_W  write data.
REQ-011 wr0_i / wr1_i  in  DATA_W/8  byte-lane write enables; all zero = read only.
REQ-012 data0_o / data1_o  out  DATA_W  read data.
REQ-013 valid0_o / valid1_o  out  1  read data valid, one-cycle pulse per accepted request.
REQ-014 ready_o  out  1  array initialised; requests are accepted only when high.
REQ-015 collision_o  out  1  pulse: both ports wrote an overlapping byte lane at the same address.

Function
REQ-016 Request accepted SHALL mean req_i & ready_o on a clock edge; non-accepted requests SHALL have no effect and produce no valid.
REQ-017 Each accepted request SHALL write enabled byte lanes and read the addressed word in the same cycle.
REQ-018 Read latency SHALL be 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from acceptance to valid_o; back-to-back requests SHALL be accepted every cycle.
REQ-019 Same-port read data SHALL be read-first: a write+read access returns the pre-write word.
REQ-020 Both ports writing the same address with overlapping lanes: port 0 SHALL win each overlapping lane; non-overlapping lanes from both ports SHALL be written.
REQ-021 collision_o SHALL pulse high in the cycle after a REQ-020 overlap, aligned with OUT_REG=0 valid timing and regardless of OUT_REG.
REQ-022 Cross-port same-address read during a write: READ_MODE=0 SHALL return the old word; READ_MODE=1 SHALL return the merged post-write word, port-0 priority applied.
REQ-023 data_o SHALL hold its last value while valid_o is low.
REQ-024 Init FSM states: INIT, READY. INIT SHALL write zero to address 0..2^ADDR_W-1, one word per cycle, ascending, with ready_o low.
REQ-025 INIT -> READY SHALL occur after the last address is written; ready_o SHALL rise in the following cycle.
REQ-026 With CLEAR_ON_RESET=0, the FSM SHALL enter READY directly; ready_o SHALL be high in the first cycle after rst_i falls; array contents are undefined.
REQ-027 The clear address counter SHALL be ADDR_W bits and SHALL NOT wrap into a second pass.

Reset
REQ-028 While rst_i is high: data0_o = data1_o = 0, valid0_o = valid1_o = 0, collision_o = 0, ready_o = 0, pipeline stages flushed.
REQ-029 Reset asserted mid-INIT SHALL restart clearing from address 0 after deassertion.
REQ-030 Reset asserted with reads in flight SHALL discard them; no valid SHALL appear afterwards for those requests.
REQ-031 Array contents SHALL NOT be modified by rst_i itself, except via INIT.

Verification
(bench parameters: DATA_W=64, ADDR_W=4, OUT_REG=0 unless stated)
REQ-032 Reset, CLEAR_ON_RESET=1 -> ready_o low for exactly 16 cycles after rst_i falls, then high; read of any address -> 0x0.
REQ-033 Port 0 writes 0x1122334455667788 at addr 3, wr=0xFF; next cycle port 1 reads addr 3 -> valid1_o one cycle later, data1_o = 0x1122334455667788; with OUT_REG=1, valid appears two cycles after acceptance.
REQ-034 Same cycle at addr 5 (old word 0): port 0 writes 0xAAAA..AA, wr=0x0F; port 1 writes 0xBBBB..BB, wr=0x3C -> collision_o pulses; word = 0x0000BBBBAAAAAAAA.
REQ-035 Addr 7 holds 0x1; port 0 writes 0x2, wr=0xFF, while port 1 reads addr 7 -> data1_o = 0x1 (READ_MODE=0), 0x2 (READ_MODE=1).
REQ-036 rst_i pulsed at INIT address 9 -> clearing restarts at 0; ready_o rises 16 cycles after the second deassertion; a request issued while ready_o=0 -> no valid, memory unchanged.
